// File: rtl/sdf_r2_bf_stage.sv
// sdf_r2_bf_stage: radix-2 single-path delay-feedback butterfly stage of the 512-point FFT pipeline.
// Define SDF_ROUND_EN for round-half-up twiddle products; the default build truncates (floor).
module sdf_r2_bf_stage #(
  parameter int DELAY = 2,
  parameter int DW    = 24,
  parameter int FRAC  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic signed [DW-1:0] din_r,
  input  logic signed [DW-1:0] din_i,
  input  logic [1:0]           state,
  input  logic signed [DW-1:0] w_r,
  input  logic signed [DW-1:0] w_i,
  output logic                 out_valid,
  output logic signed [DW-1:0] dout_r,
  output logic signed [DW-1:0] dout_i
);
  localparam int CW = $clog2(DELAY + 1);
  localparam int PW = 2 * DW + 1;
`ifdef SDF_ROUND_EN
  localparam logic signed [PW-1:0] RND = PW'(1) << (FRAC - 1);
`else
  localparam logic signed [PW-1:0] RND = '0;
`endif
  logic [CW-1:0] flush_q, flush_d;
  logic vld_q;
  logic out_valid_q, out_valid_d;
  logic signed [DW-1:0] dout_r_q, dout_i_q, dout_r_d, dout_i_d;
  logic signed [DW-1:0] dr_q [DELAY];
  logic signed [DW-1:0] di_q [DELAY];
  logic advance, bf, tw;
  logic signed [DW-1:0] xr, xi, hr, hi, tail_r, tail_i;
  logic signed [PW-1:0] pr, pi;
  always_comb begin
    advance     = in_valid | (flush_q != '0);
    bf          = state == 2'd1;
    tw          = state == 2'd2;
    xr          = in_valid ? din_r : '0;
    xi          = in_valid ? din_i : '0;
    hr          = dr_q[0];
    hi          = di_q[0];
    pr          = PW'(hr) * PW'(w_r) - PW'(hi) * PW'(w_i) + RND;
    pi          = PW'(hr) * PW'(w_i) + PW'(hi) * PW'(w_r) + RND;
    tail_r      = bf ? hr - xr : xr;
    tail_i      = bf ? hi - xi : xi;
    dout_r_d    = bf ? hr + xr : DW'(pr >>> FRAC);
    dout_i_d    = bf ? hi + xi : DW'(pi >>> FRAC);
    out_valid_d = advance & (bf | tw);
    flush_d     = in_valid ? '0 : vld_q ? CW'(DELAY) : (flush_q != '0) ? flush_q - 1'b1 : flush_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q       <= 1'b0;
      flush_q     <= '0;
      out_valid_q <= 1'b0;
      dout_r_q    <= '0;
      dout_i_q    <= '0;
      for (int k = 0; k < DELAY; k++) begin
        dr_q[k] <= '0;
        di_q[k] <= '0;
      end
    end else begin
      vld_q       <= in_valid;
      flush_q     <= flush_d;
      out_valid_q <= out_valid_d;
      if (out_valid_d) begin
        dout_r_q <= dout_r_d;
        dout_i_q <= dout_i_d;
      end
      if (advance) begin
        for (int k = 0; k < DELAY - 1; k++) begin
          dr_q[k] <= dr_q[k+1];
          di_q[k] <= di_q[k+1];
        end
        dr_q[DELAY-1] <= tail_r;
        di_q[DELAY-1] <= tail_i;
      end
    end
  end
  assign out_valid = out_valid_q;
  assign dout_r    = dout_r_q;
  assign dout_i    = dout_i_q;
endmodule

// File: tb/tb_sdf_r2_bf_stage.sv
// tb_sdf_r2_bf_stage: directed checks of the DELAY=2 SDF butterfly stage plus a golden-model frame run.
module tb_sdf_r2_bf_stage;
  localparam int DW = 24;
`ifdef SDF_ROUND_EN
  localparam int R_POS = 2;
  localparam int R_NEG = -1;
  localparam longint RND = 128;
`else
  localparam int R_POS = 1;
  localparam int R_NEG = -2;
  localparam longint RND = 0;
`endif
  localparam int M = 8388607;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic signed [DW-1:0] din_r = '0, din_i = '0, w_r = '0, w_i = '0;
  logic [1:0] state = '0;
  logic out_valid;
  logic signed [DW-1:0] dout_r, dout_i;
  int checks = 0;
  int errors = 0;
  int qr[$], qi[$];
  sdf_r2_bf_stage #(.DELAY(2), .DW(DW), .FRAC(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .din_r(din_r), .din_i(din_i),
    .state(state), .w_r(w_r), .w_i(w_i), .out_valid(out_valid), .dout_r(dout_r), .dout_i(dout_i)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic cyc(input string tag, input logic v, input int dr, input int di, input int st,
                     input int wr, input int wi, input logic eo, input int er, input int ei);
    in_valid = v;
    din_r    = DW'(dr);
    din_i    = DW'(di);
    state    = 2'(st);
    w_r      = DW'(wr);
    w_i      = DW'(wi);
    @(posedge clk);
    #1;
    chk({tag, ".valid"}, out_valid, eo);
    if (eo) begin
      chk({tag, ".re"}, dout_r, er);
      chk({tag, ".im"}, dout_i, ei);
    end
  endtask
  function automatic int w24(input longint v);
    logic signed [DW-1:0] t;
    t = v[DW-1:0];
    return int'(t);
  endfunction
  initial begin
    int xr, xi, wr, wi, hr, hi, er, ei, st;
    longint pr, pi;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.valid", out_valid, 0);
    chk("rst.re", dout_r, 0);
    chk("rst.im", dout_i, 0);
    rst_n = 1'b1;
    cyc("basic0", 1, 256, 0, 0, 0, 0, 0, 0, 0);
    cyc("basic1", 1, 512, 0, 0, 0, 0, 0, 0, 0);
    cyc("basic2", 1, 768, 0, 1, 0, 0, 1, 1024, 0);
    cyc("basic3", 1, 1024, 0, 1, 0, 0, 1, 1536, 0);
    cyc("basic4", 1, 0, 0, 2, 256, 0, 1, -512, 0);
    cyc("basic5", 1, 0, 0, 2, 0, -256, 1, 0, 512);
    cyc("drain0", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("drain1", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("drain2", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("stall0", 1, 256, 0, 0, 0, 0, 0, 0, 0);
    cyc("stall1", 1, 512, 0, 0, 0, 0, 0, 0, 0);
    cyc("stall2", 1, 768, 0, 1, 0, 0, 1, 1024, 0);
    cyc("stall_fall", 0, 0, 0, 1, 0, 0, 0, 0, 0);
    cyc("stall_fl1", 0, 0, 0, 1, 0, 0, 1, 512, 0);
    cyc("stall_fl2", 0, 0, 0, 2, 256, 0, 1, -512, 0);
    cyc("stall_resume", 1, 1024, 0, 2, 0, -256, 1, 0, -512);
    cyc("stall_dr0", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("stall_dr1", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("stall_dr2", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("flush_done", 0, 0, 0, 1, 0, 0, 0, 0, 0);
    cyc("wrap0", 1, M, 0, 0, 0, 0, 0, 0, 0);
    cyc("wrap1", 1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("wrap2", 1, M, 0, 1, 0, 0, 1, -2, 0);
    chk("wrap.noX", $isunknown({dout_r, dout_i}), 0);
    cyc("wrap3", 1, 0, 0, 1, 0, 0, 1, 0, 0);
    cyc("round0", 1, 3, 0, 0, 0, 0, 0, 0, 0);
    cyc("round1", 1, -3, 0, 0, 0, 0, 0, 0, 0);
    cyc("round_pos", 1, 0, 0, 2, 128, 0, 1, R_POS, 0);
    cyc("round_neg", 1, 0, 0, 2, 128, 0, 1, R_NEG, 0);
    cyc("round_dr0", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("round_dr1", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("round_dr2", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    qr = '{0, 0};
    qi = '{0, 0};
    for (int n = 0; n < 34; n++) begin
      st = (n < 2) ? 0 : (((n - 2) % 4) < 2 ? 1 : 2);
      xr = int'($urandom_range(0, 65535)) - 32768;
      xi = int'($urandom_range(0, 65535)) - 32768;
      wr = int'($urandom_range(0, 512)) - 256;
      wi = int'($urandom_range(0, 512)) - 256;
      hr = qr.pop_front();
      hi = qi.pop_front();
      pr = longint'(hr) * wr - longint'(hi) * wi + RND;
      pi = longint'(hr) * wi + longint'(hi) * wr + RND;
      er = (st == 1) ? w24(longint'(hr) + xr) : w24(pr >>> 8);
      ei = (st == 1) ? w24(longint'(hi) + xi) : w24(pi >>> 8);
      qr.push_back((st == 1) ? w24(longint'(hr) - xr) : xr);
      qi.push_back((st == 1) ? w24(longint'(hi) - xi) : xi);
      cyc($sformatf("frame%0d", n), 1, xr, xi, st, wr, wi, st != 0, er, ei);
    end
    cyc("pre_rst", 1, 50, 0, 1, 0, 0, 1, qr[0] + 50, qi[0]);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.valid", out_valid, 0);
    chk("arst.re", dout_r, 0);
    chk("arst.im", dout_i, 0);
    @(posedge clk);
    #1;
    chk("arst_edge.valid", out_valid, 0);
    chk("arst_edge.re", dout_r, 0);
    #2;
    rst_n = 1'b1;
    cyc("post_rst0", 0, 0, 0, 1, 0, 0, 0, 0, 0);
    cyc("post_rst1", 0, 0, 0, 1, 0, 0, 0, 0, 0);
    cyc("post_rst_dl", 1, 5, 7, 1, 0, 0, 1, 5, 7);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
